// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART transmitter and receiver.
//   DATA_BITS     - payload width of one frame
//   uart_state_t  - 3-bit FSM encoding used by uart_tx and uart_rx
//   PAR_EVEN/ODD  - parity-mode selector values
//   calc_parity   - parity bit for a byte in the selected mode
package uart_pkg;

  localparam int DATA_BITS = 8;

  localparam bit PAR_EVEN = 1'b0;
  localparam bit PAR_ODD  = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_PARITY  = 3'd3,
    S_STOP    = 3'd4,
    S_CLEANUP = 3'd5
  } uart_state_t;

  // Even mode: XOR of the data bits. Odd mode: its complement.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] i_byte,
                                       input bit i_mode);
    return (^i_byte) ^ (i_mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: bit-period tick generator shared by uart_tx and uart_rx.
//   i_clk, i_rst_n  clock / async active-low reset
//   i_clear         hold the count at 0 (no tick while asserted)
//   o_bit_end       one-cycle tick while the count equals CLK_CY_PER_BIT-1
// The count runs 0..CLK_CY_PER_BIT-1 and wraps on the tick, so a bit that
// starts with the count at 0 lasts exactly CLK_CY_PER_BIT clocks.
module uart_bit_timer #(
  parameter int CLK_CY_PER_BIT = 87
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clear,
  output logic o_bit_end
);

  localparam int CW = (CLK_CY_PER_BIT > 1) ? $clog2(CLK_CY_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_CY_PER_BIT - 1);

  logic [CW-1:0] r_count;
  logic          w_at_last;

  assign w_at_last = (r_count == LAST);
  assign o_bit_end = w_at_last && !i_clear;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_clear || w_at_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, frame = start, 8 data bits LSB-first, parity, stop.
//   i_clk, i_rst_n  clock / async active-low reset
//   i_Tx_Dv         byte valid; accepted when i_Tx_Dv && o_Tx_Ready
//   i_Tx_Byte       byte to send, sampled on the accepting edge
//   o_Tx_Ready      a byte can be accepted this cycle
//   o_Tx_Active     frame (start..stop) on the line
//   o_Tx_Serial     serial line, idles high
//   o_Tx_Done       one-cycle pulse in CLEANUP after the stop bit
// Optional macro UART_TX_HOLD_EN adds a one-byte holding register so the next
// byte can be queued while a frame is in flight.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_CY_PER_BIT = 87,
  parameter bit PARITY_ODD     = 1'b0
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_Tx_Dv,
  input  logic [DATA_BITS-1:0] i_Tx_Byte,
  output logic                 o_Tx_Ready,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Done
);

  localparam int IW = $clog2(DATA_BITS);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);

  uart_state_t          r_state;
  uart_state_t          w_next;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_parity;
  logic [IW-1:0]        r_bit_idx;
  logic                 w_accept;
  logic                 w_bit_end;
  logic                 w_timer_clr;
  logic                 w_start_frame;

  assign w_accept = i_Tx_Dv && o_Tx_Ready;

  // IDLE and CLEANUP keep the timer at 0 so every frame's start bit gets a
  // full period, including the back-to-back CLEANUP->START path.
  assign w_timer_clr = (r_state == S_IDLE) || (r_state == S_CLEANUP);

  uart_bit_timer #(
    .CLK_CY_PER_BIT(CLK_CY_PER_BIT)
  ) u_bit_timer (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clear  (w_timer_clr),
    .o_bit_end(w_bit_end)
  );

`ifdef UART_TX_HOLD_EN
  logic [DATA_BITS-1:0] r_hold;
  logic                 r_hold_full;
  logic                 w_direct;
  logic                 w_drain;
  logic                 w_hold_wr;

  // Load the shifter straight from the input only when nothing is queued;
  // any other accepted byte goes to the holding register.
  assign w_direct      = w_accept && (r_state == S_IDLE) && !r_hold_full;
  assign w_hold_wr     = w_accept && !w_direct;
  assign w_drain       = r_hold_full && ((r_state == S_IDLE) || (r_state == S_CLEANUP));
  assign w_start_frame = w_direct || w_drain;
  assign o_Tx_Ready    = !r_hold_full;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
    end else if (w_hold_wr) begin
      r_hold      <= i_Tx_Byte;
      r_hold_full <= 1'b1;
    end else if (w_drain) begin
      r_hold_full <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift  <= '0;
      r_parity <= 1'b0;
    end else if (w_drain) begin
      r_shift  <= r_hold;
      r_parity <= calc_parity(r_hold, PARITY_ODD);
    end else if (w_direct) begin
      r_shift  <= i_Tx_Byte;
      r_parity <= calc_parity(i_Tx_Byte, PARITY_ODD);
    end
  end
`else
  assign w_start_frame = w_accept && (r_state == S_IDLE);
  assign o_Tx_Ready    = (r_state == S_IDLE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift  <= '0;
      r_parity <= 1'b0;
    end else if (w_start_frame) begin
      r_shift  <= i_Tx_Byte;
      r_parity <= calc_parity(i_Tx_Byte, PARITY_ODD);
    end
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_start_frame) w_next = S_START;
      S_START:   if (w_bit_end) w_next = S_DATA;
      S_DATA:    if (w_bit_end && (r_bit_idx == LAST_IDX)) w_next = S_PARITY;
      S_PARITY:  if (w_bit_end) w_next = S_STOP;
      S_STOP:    if (w_bit_end) w_next = S_CLEANUP;
      S_CLEANUP: w_next = w_start_frame ? S_START : S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Index wraps back to 0 after the last data bit, ready for the next frame.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_bit_idx <= '0;
    end else if (r_state != S_DATA) begin
      r_bit_idx <= '0;
    end else if (w_bit_end) begin
      r_bit_idx <= r_bit_idx + 1'b1;
    end
  end

  // Outputs decode the registered state, so reset forces the line high at once.
  always_comb begin
    o_Tx_Serial = 1'b1;
    o_Tx_Active = 1'b0;
    o_Tx_Done   = 1'b0;
    case (r_state)
      S_START:   begin o_Tx_Serial = 1'b0;               o_Tx_Active = 1'b1; end
      S_DATA:    begin o_Tx_Serial = r_shift[r_bit_idx]; o_Tx_Active = 1'b1; end
      S_PARITY:  begin o_Tx_Serial = r_parity;           o_Tx_Active = 1'b1; end
      S_STOP:    begin o_Tx_Serial = 1'b1;               o_Tx_Active = 1'b1; end
      S_CLEANUP: o_Tx_Done = 1'b1;
      default:   ;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx with N = 8 clocks per bit.
// u_dut_even uses even parity, u_dut_odd odd parity; frames are compared
// cycle by cycle against hand-computed 11-bit frame vectors
// {stop, parity, d7..d0, start}.
module tb_uart_tx;

  localparam int N  = 8;
  localparam int FL = 11 * N;

  logic       clk;
  logic       rst_n;
  logic       dv0, dv1;
  logic [7:0] byte0, byte1;
  logic       rdy0, act0, ser0, done0;
  logic       rdy1, act1, ser1, done1;

  int n_checks;
  int n_errors;

  uart_tx #(.CLK_CY_PER_BIT(N), .PARITY_ODD(1'b0)) u_dut_even (
    .i_clk(clk), .i_rst_n(rst_n), .i_Tx_Dv(dv0), .i_Tx_Byte(byte0),
    .o_Tx_Ready(rdy0), .o_Tx_Active(act0), .o_Tx_Serial(ser0), .o_Tx_Done(done0)
  );

  uart_tx #(.CLK_CY_PER_BIT(N), .PARITY_ODD(1'b1)) u_dut_odd (
    .i_clk(clk), .i_rst_n(rst_n), .i_Tx_Dv(dv1), .i_Tx_Byte(byte1),
    .o_Tx_Ready(rdy1), .o_Tx_Active(act1), .o_Tx_Serial(ser1), .o_Tx_Done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Sends one byte on the selected instance and checks the whole frame from
  // the accepting edge (k = 0) through the first IDLE cycle (k = 11N+1).
  task automatic run_frame(input int sel, input logic [7:0] b,
                           input logic [10:0] exp_frame, input bit inject);
    logic [10:0] obs;
    int   nbad, nact, ndone, first_done, overlap;
    logic s, a, d, exp_s;
    obs = '0; nbad = 0; nact = 0; ndone = 0; first_done = -1; overlap = 0;
    @(negedge clk);
    if (sel == 0) begin dv0 = 1'b1; byte0 = b; end
    else          begin dv1 = 1'b1; byte1 = b; end
    @(posedge clk);
    #1;
    dv0 = 1'b0; dv1 = 1'b0;
    for (int k = 0; k <= FL + 1; k++) begin
      if (inject && k == 19) begin dv0 = 1'b1; byte0 = 8'h3C; end
      if (inject && k == 20) dv0 = 1'b0;
      s = (sel == 0) ? ser0  : ser1;
      a = (sel == 0) ? act0  : act1;
      d = (sel == 0) ? done0 : done1;
      exp_s = (k < FL) ? exp_frame[k / N] : 1'b1;
      if (s !== exp_s) nbad++;
      if (a !== (k < FL)) nact++;
      if (k < FL && (k % N) == N / 2) obs[k / N] = s;
      if (d) begin ndone++; if (first_done < 0) first_done = k; end
      if (a && d) overlap++;
      @(posedge clk);
      #1;
    end
    check_eq("frame_bits", int'(obs), int'(exp_frame));
    check_eq("serial_bad_cycles", nbad, 0);
    check_eq("active_bad_cycles", nact, 0);
    check_eq("done_cycle", first_done, FL);
    check_eq("done_count", ndone, 1);
    check_eq("active_done_overlap", overlap, 0);
  endtask

  initial begin
    int cnt;
    n_checks = 0; n_errors = 0;
    rst_n = 1'b0; dv0 = 1'b0; dv1 = 1'b0; byte0 = '0; byte1 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_serial", int'(ser0), 1);
    check_eq("rst_active", int'(act0), 0);
    check_eq("rst_done", int'(done0), 0);
    check_eq("rst_ready", int'(rdy0), 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 0xA5 even parity -> 0,1,0,1,0,0,1,0,1,0,1
    run_frame(0, 8'hA5, 11'h54A, 1'b0);
    check_eq("ready_after_frame", int'(rdy0), 1);

    // odd parity: 0x07 -> parity 0, 0x00 -> parity 1
    run_frame(1, 8'h07, 11'h40E, 1'b0);
    run_frame(1, 8'h00, 11'h600, 1'b0);

`ifndef UART_TX_HOLD_EN
    // 0x3C offered mid-frame while not ready must be dropped
    run_frame(0, 8'hA5, 11'h54A, 1'b1);
    cnt = 0;
    for (int k = 0; k < 30; k++) begin
      if (act0) cnt++;
      @(posedge clk);
      #1;
    end
    check_eq("dropped_byte_no_frame", cnt, 0);
`else
    // back-to-back frames through the holding register
    begin
      int ndone, first_d, second_d, nbad;
      logic exp_s;
      logic [10:0] f1, f2;
      f1 = 11'h422; f2 = 11'h444;
      ndone = 0; first_d = -1; second_d = -1; nbad = 0;
      @(negedge clk);
      dv0 = 1'b1; byte0 = 8'h11;
      @(posedge clk);
      #1;
      dv0 = 1'b0;
      for (int k = 0; k <= 2 * FL + 3; k++) begin
        if (k == 4) begin dv0 = 1'b1; byte0 = 8'h22; end
        if (k == 5) dv0 = 1'b0;
        if (k == 6) check_eq("hold_ready_low", int'(rdy0), 0);
        if (k < FL)                          exp_s = f1[k / N];
        else if (k >= FL + 1 && k < 2*FL + 1) exp_s = f2[(k - FL - 1) / N];
        else                                 exp_s = 1'b1;
        if (ser0 !== exp_s) nbad++;
        if (done0) begin
          ndone++;
          if (first_d < 0) first_d = k; else second_d = k;
        end
        @(posedge clk);
        #1;
      end
      check_eq("hold_serial_bad_cycles", nbad, 0);
      check_eq("hold_done_count", ndone, 2);
      check_eq("hold_done1_cycle", first_d, FL);
      check_eq("hold_done2_cycle", second_d, 2 * FL + 1);
      check_eq("hold_ready_end", int'(rdy0), 1);
    end
`endif

    // reset in the middle of data bit 3 of 0xA5 (bit value 0)
    @(negedge clk);
    dv0 = 1'b1; byte0 = 8'hA5;
    @(posedge clk);
    #1;
    dv0 = 1'b0;
    repeat (4 * N + 2) @(posedge clk);
    #2;
    check_eq("pre_rst_bit3", int'(ser0), 0);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_serial", int'(ser0), 1);
    check_eq("midrst_active", int'(act0), 0);
    check_eq("midrst_ready", int'(rdy0), 1);
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      if (done0) cnt++;
      @(posedge clk);
      #1;
    end
    check_eq("midrst_no_done", cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    // 0x5A even parity -> parity 0
    run_frame(0, 8'h5A, 11'h4B4, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary, limit 200000");
    $fatal(1);
  end

endmodule
